idex_operand_stage: RTL and testbench
=====================================

Name: idex_operand_stage

Overview:
- ID/EX pipeline stage that drives the ALU side of control_hazard_alu_if: alucode_IDEX, oprnd1, oprnd2.
- Registers decode outputs and forwards operands from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles.
- Consumes ALU flags to resolve BEQ/BNE in EX, producing a redirect plus an IF/ID flush.
- One instance per core, between decode and the ALU.

Parameters:
- WORD_W, 32, datapath width
- REG_AW, 5, register index width

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- stall_in  in  1  memory stall; freezes all state
- id_valid  in  1  decode slot holds a real instruction
- id_alucode  in  aluop_t  ALU operation
- id_rs, id_rt  in  5 each  source register indices
- id_rsdat, id_rtdat  in  32 each  register file read data
- id_imm  in  32  extended immediate
- id_shamt  in  5  shift amount
- id_alusrc  in  opsrc_t  oprnd2 source: OP_RT, OP_IMM, OP_SHAMT
- id_dest  in  5  destination register
- id_regwen, id_memread, id_memwrite  in  1 each  control bits
- id_branch  in  brtype_t  BR_NONE, BR_EQ, BR_NE
- id_brtarget  in  32  branch target
- exmem_regwen  in  1;  exmem_dest  in  5;  exmem_result  in  32
- memwb_regwen  in  1;  memwb_dest  in  5;  memwb_wdat  in  32
- alucode_IDEX  out  aluop_t;  oprnd1, oprnd2  out  32 each  (to ALU)
- alurst  in  32;  zroflg  in  1  (from ALU)
- ex_valid, ex_regwen, ex_memread, ex_memwrite  out  1 each
- ex_dest  out  5;  ex_result  out  32 (= alurst);  ex_storedat  out  32 (forwarded rt)
- id_stall  out  1  hold PC and IF/ID
- br_taken  out  1;  br_target  out  32;  flush_ifid  out  1

Behaviour:
- Reset (nRST low, async): every ID/EX register cleared.
  - ex_valid=0, all control bits 0, alucode ALU_SLL, stored data 0.
  - Outputs then: br_taken=0, flush_ifid=0, id_stall=0.
- Register update at each CLK rise when stall_in=0. When stall_in=1, all registers hold and all combinational outputs keep their current values.
- Bubble: ex_valid=0, regwen/memread/memwrite=0, branch BR_NONE. Registered data is don't-care but is zeroed.
- Forwarding, evaluated independently for rs and rt on the EX-stage indices:
  - EX/MEM wins if exmem_regwen, exmem_dest!=0 and it matches.
  - Otherwise MEM/WB if memwb_regwen, memwb_dest!=0 and it matches.
  - Otherwise the registered value.
  - Register 0 is never forwarded.
- oprnd1 = forwarded rs.
- oprnd2 selection:
  - OP_RT: forwarded rt.
  - OP_IMM: registered imm.
  - OP_SHAMT: zero-extended shamt.
- For ALU_SLL/ALU_SRL, oprnd1 = forwarded rt, since the ALU shifts oprnd1.
- ex_storedat = forwarded rt, always.
- Load-use: id_stall = ex_valid & ex_memread & ex_dest!=0 & (ex_dest==id_rs | (ex_dest==id_rt & rt is a source)). On the next edge, a bubble loads into ID/EX and the decode slot is held.
- Branch resolved in EX: br_taken = ex_valid & ((BR_EQ & zroflg) | (BR_NE & ~zroflg)). The ALU uses ALU_SUB for branches.
- When br_taken: br_target = registered target, flush_ifid=1, and the next edge loads a bubble.
- Simultaneous flush and load-use: flush wins, and id_stall is forced to 0.
- id_valid=0: a bubble loads.
- Zero-cycle latency from operands to alucode/oprnd; one-cycle latency from ID to EX.

Decomposition:
- cpu_types_pkg:
  - typedefs opsrc_t and brtype_t, each 2 bits.
  - aluop_t, which already exists.
  - typedef idex_t, a packed struct of the ID/EX register.
- Sub-module fwd_mux: pure combinational per-operand forwarding selector, instantiated twice.

Test Plan:
- Reset mid-run with ex_valid=1 and a BR_EQ branch:
  - nRST low → ex_valid=0 and br_taken=0 immediately, without waiting for CLK.
- ADD r3,r1,r2 (rsdat=5, rtdat=7) with exmem writing r1=100 and memwb writing r1=200:
  - oprnd1=100, oprnd2=7.
  - Same case with exmem_dest=0 → oprnd1=200.
- LW r4 in EX followed by ADD r5,r4,r4 in ID:
  - id_stall=1 for one cycle, then a bubble (ex_valid=0).
  - Next cycle, memwb forwarding supplies r4.
- BNE in EX with zroflg=0 and target 0x40:
  - br_taken=1, br_target=0x40, flush_ifid=1.
  - Next cycle ex_valid=0.
- Load-use and taken branch in the same cycle:
  - id_stall=0, flush_ifid=1.
- stall_in=1 for 3 cycles while id_* changes:
  - alucode_IDEX, oprnd1 and oprnd2 are unchanged, and br_taken holds its value.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared datapath widths, operand/branch encodings and the ID/EX pipeline register layout.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } aluop_t;

  typedef enum logic [1:0] {
    OP_RT    = 2'd0,
    OP_IMM   = 2'd1,
    OP_SHAMT = 2'd2
  } opsrc_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } brtype_t;

  typedef struct packed {
    logic              valid;
    aluop_t            alucode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [WORD_W-1:0] rsdat;
    logic [WORD_W-1:0] rtdat;
    logic [WORD_W-1:0] imm;
    logic [REG_AW-1:0] shamt;
    opsrc_t            alusrc;
    logic [REG_AW-1:0] dest;
    logic              regwen;
    logic              memread;
    logic              memwrite;
    brtype_t           branch;
    logic [WORD_W-1:0] brtarget;
  } idex_t;

endpackage

// File: rtl/idex_operand_stage_if.sv
// ALU-side bundle: operation and operands out to the ALU, result and zero flag back.
interface idex_operand_stage_if;
  import cpu_types_pkg::*;

  aluop_t            alucode_IDEX;
  logic [WORD_W-1:0] oprnd1;
  logic [WORD_W-1:0] oprnd2;
  logic [WORD_W-1:0] alurst;
  logic              zroflg;

  modport master (output alucode_IDEX, oprnd1, oprnd2, input alurst, zroflg);
  modport slave  (input alucode_IDEX, oprnd1, oprnd2, output alurst, zroflg);

endinterface

// File: rtl/fwd_mux.sv
// Per-operand bypass select: EX/MEM beats MEM/WB beats the registered value; r0 never bypassed.
module fwd_mux
  import cpu_types_pkg::*;
(
  input  logic [REG_AW-1:0] src_idx_i,
  input  logic [WORD_W-1:0] reg_dat_i,
  input  logic              exmem_regwen_i,
  input  logic [REG_AW-1:0] exmem_dest_i,
  input  logic [WORD_W-1:0] exmem_result_i,
  input  logic              memwb_regwen_i,
  input  logic [REG_AW-1:0] memwb_dest_i,
  input  logic [WORD_W-1:0] memwb_wdat_i,
  output logic [WORD_W-1:0] fwd_dat_o
);

  always_comb begin
    fwd_dat_o = reg_dat_i;
    if (exmem_regwen_i && (exmem_dest_i != '0) && (exmem_dest_i == src_idx_i)) begin
      fwd_dat_o = exmem_result_i;
    end else if (memwb_regwen_i && (memwb_dest_i != '0) && (memwb_dest_i == src_idx_i)) begin
      fwd_dat_o = memwb_wdat_i;
    end
  end

endmodule

// File: rtl/idex_operand_stage.sv
// ID/EX register with operand bypassing, load-use bubble insertion and EX-stage BEQ/BNE resolution.
module idex_operand_stage
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              stall_in,
  input  logic              id_valid,
  input  aluop_t            id_alucode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [WORD_W-1:0] id_rsdat,
  input  logic [WORD_W-1:0] id_rtdat,
  input  logic [WORD_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_shamt,
  input  opsrc_t            id_alusrc,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwen,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  brtype_t           id_branch,
  input  logic [WORD_W-1:0] id_brtarget,
  input  logic              exmem_regwen,
  input  logic [REG_AW-1:0] exmem_dest,
  input  logic [WORD_W-1:0] exmem_result,
  input  logic              memwb_regwen,
  input  logic [REG_AW-1:0] memwb_dest,
  input  logic [WORD_W-1:0] memwb_wdat,
  idex_operand_stage_if.master alu,
  output logic              ex_valid,
  output logic              ex_regwen,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [REG_AW-1:0] ex_dest,
  output logic [WORD_W-1:0] ex_result,
  output logic [WORD_W-1:0] ex_storedat,
  output logic              id_stall,
  output logic              br_taken,
  output logic [WORD_W-1:0] br_target,
  output logic              flush_ifid
);

  idex_t             idex_q, idex_d;
  logic [WORD_W-1:0] rs_fwd, rt_fwd;
  logic              rt_is_src, load_use, ex_is_shift;

  fwd_mux u_fwd_rs (
    .src_idx_i(idex_q.rs), .reg_dat_i(idex_q.rsdat),
    .exmem_regwen_i(exmem_regwen), .exmem_dest_i(exmem_dest), .exmem_result_i(exmem_result),
    .memwb_regwen_i(memwb_regwen), .memwb_dest_i(memwb_dest), .memwb_wdat_i(memwb_wdat),
    .fwd_dat_o(rs_fwd)
  );

  fwd_mux u_fwd_rt (
    .src_idx_i(idex_q.rt), .reg_dat_i(idex_q.rtdat),
    .exmem_regwen_i(exmem_regwen), .exmem_dest_i(exmem_dest), .exmem_result_i(exmem_result),
    .memwb_regwen_i(memwb_regwen), .memwb_dest_i(memwb_dest), .memwb_wdat_i(memwb_wdat),
    .fwd_dat_o(rt_fwd)
  );

  // rt is read by register-operand ALU ops, shifts, stores and branch compares.
  assign rt_is_src = (id_alusrc == OP_RT) || id_memwrite || (id_branch != BR_NONE) ||
                     (id_alucode == ALU_SLL) || (id_alucode == ALU_SRL);

  assign load_use = idex_q.valid && idex_q.memread && (idex_q.dest != '0) &&
                    ((idex_q.dest == id_rs) || ((idex_q.dest == id_rt) && rt_is_src));

  assign br_taken = idex_q.valid && (((idex_q.branch == BR_EQ) && alu.zroflg) ||
                                     ((idex_q.branch == BR_NE) && !alu.zroflg));
  assign br_target  = idex_q.brtarget;
  assign flush_ifid = br_taken;
  assign id_stall   = load_use && !br_taken;

  // The ALU shifts oprnd1, so shifts route rt there instead of rs.
  assign ex_is_shift      = (idex_q.alucode == ALU_SLL) || (idex_q.alucode == ALU_SRL);
  assign alu.alucode_IDEX = idex_q.alucode;
  assign alu.oprnd1       = ex_is_shift ? rt_fwd : rs_fwd;

  always_comb begin
    case (idex_q.alusrc)
      OP_IMM:   alu.oprnd2 = idex_q.imm;
      OP_SHAMT: alu.oprnd2 = {{(WORD_W-REG_AW){1'b0}}, idex_q.shamt};
      default:  alu.oprnd2 = rt_fwd;
    endcase
  end

  assign ex_valid    = idex_q.valid;
  assign ex_regwen   = idex_q.regwen;
  assign ex_memread  = idex_q.memread;
  assign ex_memwrite = idex_q.memwrite;
  assign ex_dest     = idex_q.dest;
  assign ex_result   = alu.alurst;
  assign ex_storedat = rt_fwd;

  always_comb begin
    idex_d = '0;
    if (id_valid && !br_taken && !id_stall) begin
      idex_d.valid    = 1'b1;
      idex_d.alucode  = id_alucode;
      idex_d.rs       = id_rs;
      idex_d.rt       = id_rt;
      idex_d.rsdat    = id_rsdat;
      idex_d.rtdat    = id_rtdat;
      idex_d.imm      = id_imm;
      idex_d.shamt    = id_shamt;
      idex_d.alusrc   = id_alusrc;
      idex_d.dest     = id_dest;
      idex_d.regwen   = id_regwen;
      idex_d.memread  = id_memread;
      idex_d.memwrite = id_memwrite;
      idex_d.branch   = id_branch;
      idex_d.brtarget = id_brtarget;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idex_q <= '0;
    end else if (!stall_in) begin
      idex_q <= idex_d;
    end
  end

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage: reset, bypassing, operand select, load-use, branch, stall.
module tb_idex_operand_stage;
  import cpu_types_pkg::*;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              stall_in;
  logic              id_valid;
  aluop_t            id_alucode;
  logic [REG_AW-1:0] id_rs, id_rt, id_shamt, id_dest;
  logic [WORD_W-1:0] id_rsdat, id_rtdat, id_imm, id_brtarget;
  opsrc_t            id_alusrc;
  logic              id_regwen, id_memread, id_memwrite;
  brtype_t           id_branch;
  logic              exmem_regwen, memwb_regwen;
  logic [REG_AW-1:0] exmem_dest, memwb_dest;
  logic [WORD_W-1:0] exmem_result, memwb_wdat;
  logic              ex_valid, ex_regwen, ex_memread, ex_memwrite;
  logic [REG_AW-1:0] ex_dest;
  logic [WORD_W-1:0] ex_result, ex_storedat, br_target;
  logic              id_stall, br_taken, flush_ifid;

  int compared   = 0;
  int mismatched = 0;

  idex_operand_stage_if alu_if ();

  idex_operand_stage dut (
    .CLK(CLK), .nRST(nRST), .stall_in(stall_in),
    .id_valid(id_valid), .id_alucode(id_alucode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rsdat(id_rsdat), .id_rtdat(id_rtdat), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_alusrc(id_alusrc), .id_dest(id_dest), .id_regwen(id_regwen),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
    .id_brtarget(id_brtarget),
    .exmem_regwen(exmem_regwen), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
    .memwb_regwen(memwb_regwen), .memwb_dest(memwb_dest), .memwb_wdat(memwb_wdat),
    .alu(alu_if.master),
    .ex_valid(ex_valid), .ex_regwen(ex_regwen), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_dest(ex_dest), .ex_result(ex_result),
    .ex_storedat(ex_storedat), .id_stall(id_stall), .br_taken(br_taken),
    .br_target(br_target), .flush_ifid(flush_ifid)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic id_clear();
    id_valid = 1'b0; id_alucode = ALU_SLL; id_rs = '0; id_rt = '0;
    id_rsdat = '0; id_rtdat = '0; id_imm = '0; id_shamt = '0; id_alusrc = OP_RT;
    id_dest = '0; id_regwen = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
    id_branch = BR_NONE; id_brtarget = '0;
  endtask

  task automatic fwd_clear();
    exmem_regwen = 1'b0; exmem_dest = '0; exmem_result = '0;
    memwb_regwen = 1'b0; memwb_dest = '0; memwb_wdat = '0;
  endtask

  task automatic id_rtype(input aluop_t op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [4:0] rd);
    id_clear();
    id_valid = 1'b1; id_alucode = op; id_rs = rs; id_rt = rt;
    id_rsdat = rsd; id_rtdat = rtd; id_dest = rd; id_regwen = 1'b1; id_alusrc = OP_RT;
  endtask

  task automatic test_reset();
    #3;
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL rst_ex_valid: got %b want 0", ex_valid); end
    compared++; if (alu_if.alucode_IDEX !== ALU_SLL) begin mismatched++; $display("FAIL rst_alucode: got %0d want %0d", alu_if.alucode_IDEX, ALU_SLL); end
    compared++; if ({br_taken, flush_ifid, id_stall} !== 3'b000) begin mismatched++; $display("FAIL rst_ctrl: got %b want 000", {br_taken, flush_ifid, id_stall}); end
    compared++; if (alu_if.oprnd1 !== 32'h0) begin mismatched++; $display("FAIL rst_oprnd1: got %0h want 0", alu_if.oprnd1); end
    @(negedge CLK);
    nRST = 1'b1;
    // Mid-run async reset with a taken BEQ sitting in EX
    id_rtype(ALU_SUB, 5'd1, 5'd2, 32'd3, 32'd3, 5'd0);
    id_regwen = 1'b0; id_branch = BR_EQ; id_brtarget = 32'h80;
    alu_if.zroflg = 1'b1;
    cyc();
    id_clear();
    #1;
    compared++; if ({ex_valid, br_taken} !== 2'b11) begin mismatched++; $display("FAIL pre_rst_beq: got %b want 11", {ex_valid, br_taken}); end
    #1 nRST = 1'b0;
    #1;
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL async_rst_valid: got %b want 0", ex_valid); end
    compared++; if ({br_taken, flush_ifid} !== 2'b00) begin mismatched++; $display("FAIL async_rst_br: got %b want 00", {br_taken, flush_ifid}); end
    #1 nRST = 1'b1;
    alu_if.zroflg = 1'b0;
  endtask

  task automatic test_forwarding();
    fwd_clear(); id_clear(); cyc();
    id_rtype(ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 5'd3);
    cyc();
    id_clear();
    exmem_regwen = 1'b1; exmem_dest = 5'd1; exmem_result = 32'd100;
    memwb_regwen = 1'b1; memwb_dest = 5'd1; memwb_wdat = 32'd200;
    alu_if.alurst = 32'h1234;
    #1;
    compared++; if (alu_if.oprnd1 !== 32'd100) begin mismatched++; $display("FAIL fwd_exmem_rs: got %0d want 100", alu_if.oprnd1); end
    compared++; if (alu_if.oprnd2 !== 32'd7) begin mismatched++; $display("FAIL fwd_rt_plain: got %0d want 7", alu_if.oprnd2); end
    compared++; if ({ex_valid, ex_regwen, ex_dest} !== {1'b1, 1'b1, 5'd3}) begin mismatched++; $display("FAIL add_ex_ctrl: got %b want 1100011", {ex_valid, ex_regwen, ex_dest}); end
    compared++; if (ex_result !== 32'h1234) begin mismatched++; $display("FAIL ex_result: got %0h want 1234", ex_result); end
    exmem_dest = 5'd0;
    #1;
    compared++; if (alu_if.oprnd1 !== 32'd200) begin mismatched++; $display("FAIL fwd_memwb_rs: got %0d want 200", alu_if.oprnd1); end
    memwb_dest = 5'd2;
    #1;
    compared++; if ({alu_if.oprnd1, alu_if.oprnd2} !== {32'd5, 32'd200}) begin mismatched++; $display("FAIL fwd_memwb_rt: got %0d/%0d want 5/200", alu_if.oprnd1, alu_if.oprnd2); end
    compared++; if (ex_storedat !== 32'd200) begin mismatched++; $display("FAIL storedat_fwd: got %0d want 200", ex_storedat); end
  endtask

  task automatic test_operand_sel();
    fwd_clear(); id_clear();
    // ADDI r6, r0, 0x1234 with a bogus write to r0 in EX/MEM
    id_rtype(ALU_ADD, 5'd0, 5'd6, 32'd0, 32'd0, 5'd6);
    id_alusrc = OP_IMM; id_imm = 32'h1234;
    cyc();
    id_clear();
    exmem_regwen = 1'b1; exmem_dest = 5'd0; exmem_result = 32'hDEAD;
    #1;
    compared++; if (alu_if.oprnd1 !== 32'd0) begin mismatched++; $display("FAIL r0_no_fwd: got %0h want 0", alu_if.oprnd1); end
    compared++; if (alu_if.oprnd2 !== 32'h1234) begin mismatched++; $display("FAIL imm_sel: got %0h want 1234", alu_if.oprnd2); end
    fwd_clear();
    id_rtype(ALU_SLL, 5'd1, 5'd2, 32'd77, 32'd9, 5'd7);
    id_alusrc = OP_SHAMT; id_shamt = 5'd4;
    cyc();
    id_clear();
    #1;
    compared++; if ({alu_if.oprnd1, alu_if.oprnd2} !== {32'd9, 32'd4}) begin mismatched++; $display("FAIL sll_ops: got %0d/%0d want 9/4", alu_if.oprnd1, alu_if.oprnd2); end
    exmem_regwen = 1'b1; exmem_dest = 5'd2; exmem_result = 32'h55;
    #1;
    compared++; if (alu_if.oprnd1 !== 32'h55) begin mismatched++; $display("FAIL sll_fwd_rt: got %0h want 55", alu_if.oprnd1); end
  endtask

  task automatic test_load_use();
    fwd_clear(); id_clear(); cyc();
    // LW r4, 4(r1)
    id_rtype(ALU_ADD, 5'd1, 5'd0, 32'd8, 32'd0, 5'd4);
    id_alusrc = OP_IMM; id_imm = 32'd4; id_memread = 1'b1;
    cyc();
    id_rtype(ALU_ADD, 5'd4, 5'd4, 32'hBAD, 32'hBAD, 5'd5);
    #1;
    compared++; if ({id_stall, ex_memread} !== 2'b11) begin mismatched++; $display("FAIL lu_stall: got %b want 11", {id_stall, ex_memread}); end
    cyc();
    #1;
    compared++; if ({ex_valid, id_stall} !== 2'b00) begin mismatched++; $display("FAIL lu_bubble: got %b want 00", {ex_valid, id_stall}); end
    cyc();
    id_clear();
    memwb_regwen = 1'b1; memwb_dest = 5'd4; memwb_wdat = 32'h77;
    #1;
    compared++; if ({alu_if.oprnd1, alu_if.oprnd2} !== {32'h77, 32'h77}) begin mismatched++; $display("FAIL lu_memwb_fwd: got %0h/%0h want 77/77", alu_if.oprnd1, alu_if.oprnd2); end
    compared++; if ({ex_valid, ex_dest} !== {1'b1, 5'd5}) begin mismatched++; $display("FAIL lu_add_ex: got %b want 100101", {ex_valid, ex_dest}); end
  endtask

  task automatic test_branch();
    fwd_clear(); id_clear(); cyc();
    id_rtype(ALU_SUB, 5'd1, 5'd2, 32'd1, 32'd2, 5'd0);
    id_regwen = 1'b0; id_branch = BR_NE; id_brtarget = 32'h40;
    cyc();
    id_rtype(ALU_ADD, 5'd1, 5'd2, 32'd1, 32'd2, 5'd9);
    alu_if.zroflg = 1'b1;
    #1;
    compared++; if ({br_taken, flush_ifid} !== 2'b00) begin mismatched++; $display("FAIL bne_not_taken: got %b want 00", {br_taken, flush_ifid}); end
    alu_if.zroflg = 1'b0;
    #1;
    compared++; if ({br_taken, flush_ifid} !== 2'b11) begin mismatched++; $display("FAIL bne_taken: got %b want 11", {br_taken, flush_ifid}); end
    compared++; if (br_target !== 32'h40) begin mismatched++; $display("FAIL bne_target: got %0h want 40", br_target); end
    cyc();
    #1;
    compared++; if ({ex_valid, br_taken} !== 2'b00) begin mismatched++; $display("FAIL bne_flush_bubble: got %b want 00", {ex_valid, br_taken}); end
  endtask

  task automatic test_flush_vs_loaduse();
    fwd_clear(); id_clear(); cyc();
    id_rtype(ALU_SUB, 5'd1, 5'd2, 32'd0, 32'd0, 5'd4);
    id_memread = 1'b1; id_branch = BR_EQ; id_brtarget = 32'h100;
    cyc();
    id_rtype(ALU_ADD, 5'd4, 5'd4, 32'd0, 32'd0, 5'd5);
    alu_if.zroflg = 1'b1;
    #1;
    compared++; if ({id_stall, flush_ifid} !== 2'b01) begin mismatched++; $display("FAIL flush_wins: got %b want 01", {id_stall, flush_ifid}); end
    alu_if.zroflg = 1'b0;
    #1;
    compared++; if ({id_stall, flush_ifid} !== 2'b10) begin mismatched++; $display("FAIL lu_no_flush: got %b want 10", {id_stall, flush_ifid}); end
    alu_if.zroflg = 1'b1;
    cyc();
    id_clear();
    #1;
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL flush_lu_bubble: got %b want 0", ex_valid); end
  endtask

  task automatic test_stall_in();
    fwd_clear(); id_clear(); cyc();
    id_rtype(ALU_SUB, 5'd1, 5'd2, 32'd11, 32'd22, 5'd0);
    id_regwen = 1'b0; id_branch = BR_EQ; id_brtarget = 32'h200;
    alu_if.zroflg = 1'b1;
    cyc();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_rtype(ALU_OR, 5'(i + 3), 5'(i + 4), 32'(i + 100), 32'(i + 200), 5'(i + 8));
      cyc();
      compared++; if (alu_if.alucode_IDEX !== ALU_SUB) begin mismatched++; $display("FAIL stall_alucode[%0d]: got %0d want %0d", i, alu_if.alucode_IDEX, ALU_SUB); end
      compared++; if ({alu_if.oprnd1, alu_if.oprnd2} !== {32'd11, 32'd22}) begin mismatched++; $display("FAIL stall_ops[%0d]: got %0d/%0d want 11/22", i, alu_if.oprnd1, alu_if.oprnd2); end
      compared++; if ({br_taken, br_target} !== {1'b1, 32'h200}) begin mismatched++; $display("FAIL stall_br[%0d]: got %b/%0h want 1/200", i, br_taken, br_target); end
    end
    stall_in = 1'b0;
    id_clear();
    cyc();
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("FAIL stall_release_bubble: got %b want 0", ex_valid); end
  endtask

  initial begin
    nRST = 1'b0;
    stall_in = 1'b0;
    alu_if.alurst = '0;
    alu_if.zroflg = 1'b0;
    id_clear();
    fwd_clear();
    test_reset();
    test_forwarding();
    test_operand_sel();
    test_load_use();
    test_branch();
    test_flush_vs_loaduse();
    test_stall_in();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
